uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1024, giving the idle-hold limit in clk cycles (≥2).
REQ-003 The block SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-004 The block SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid  in  NREQ  per-requester byte valid.
REQ-006 The block SHALL have port req_data  in  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 The block SHALL have port req_last  in  NREQ  marks the final byte of the requester's message.
REQ-008 The block SHALL have port req_ready  out  NREQ  one-cycle accept pulse; a byte transfers when valid and ready are both high.
REQ-009 The block SHALL have port grant  out  NREQ  one-hot owner of the transmitter; all zero when there is no owner.
REQ-010 The block SHALL have port tx_start  out  1  one-cycle transmit trigger to the UART transmitter.
REQ-011 The block SHALL have port tx_byte  out  8  byte to transmit, held stable from tx_start until tx_done.
REQ-012 The block SHALL have port tx_done  in  1  one-cycle pulse from the transmitter after the stop bit.
REQ-013 The block SHALL have port timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-014 The block SHALL implement states IDLE, HOLD, START and WAIT.
REQ-015 IDLE: when any req_valid is high, the block SHALL select the first requester at or after rr_ptr (round-robin, wrapping NREQ-1 to 0), assert its grant on the next cycle, and enter HOLD.
REQ-016 HOLD: when req_valid[g] is high, the block SHALL pulse req_ready[g] for one cycle, capture req_data and req_last into tx_byte and last_q, and enter START.
REQ-017 START: the block SHALL drive tx_start high for exactly one cycle, then enter WAIT.
REQ-018 WAIT: on tx_done with last_q=1, the block SHALL clear grant, set rr_ptr to g+1 mod NREQ, and enter IDLE; on tx_done with last_q=0, it SHALL return to HOLD with the grant kept.
REQ-019 tx_done outside WAIT SHALL be ignored; req_valid from non-granted requesters SHALL never produce req_ready.
REQ-020 Grant SHALL be message-granular: no other requester is granted between the first and the last byte of a message.
REQ-021 Latency SHALL be: valid in IDLE at cycle N gives grant at N+1, req_ready at N+2, tx_start at N+3; after tx_done in WAIT (last_q=0), the next req_ready is no earlier than 2 cycles later.
REQ-022 If req_valid[g] is held high in HOLD, the back-to-back bytes SHALL be accepted without gaps beyond REQ-021.
REQ-023 A requester deasserting valid mid-message SHALL keep its grant (subject to REQ-027).
REQ-024 grant SHALL always be one-hot or zero, and req_ready SHALL be a subset of grant.

Reset
REQ-025 Reset SHALL take priority over all events, including reset in the middle of a byte or message, and SHALL force: state IDLE, grant 0, req_ready 0, tx_start 0, tx_byte 8'h00, timeout 0, rr_ptr 0, last_q 0, watchdog counter 0.
REQ-026 After reset, a tx_done pulse from a byte in flight SHALL be ignored per REQ-019.

Configuration
REQ-027 With UART_ARB_TIMEOUT_EN defined, in HOLD the block SHALL count cycles with req_valid[g] low (counter cleared on entering HOLD or on any valid); on reaching TIMEOUT_CYC it SHALL pulse timeout, clear grant, advance rr_ptr to g+1, and enter IDLE.
REQ-028 Without UART_ARB_TIMEOUT_EN, the block SHALL omit the counter, tie timeout to 0, and keep the grant in HOLD indefinitely.

Verification
REQ-029 Single message: req0 sends 8'h41 then 8'h42 (last=1), tx_done 10 cycles after each tx_start -> tx_byte sequence 41,42; grant=0001 throughout; then grant=0 and rr_ptr=1.
REQ-030 Contention: all 4 requesters assert one-byte messages at once from reset -> service order 0,1,2,3; each grant is exclusive.
REQ-031 Multi-byte lock: req1 sends a 3-byte message while req2 is valid -> req2 is granted only after req1's third tx_done.
REQ-032 Reset mid-WAIT: reset asserted during WAIT, then tx_done pulsed -> all outputs at reset values; no tx_start and no grant.
REQ-033 Timeout (macro on, TIMEOUT_CYC=16): req3 sends a non-last byte, then drops valid -> timeout pulses 16 cycles after HOLD entry; grant=0; a pending req0 is granted next.
REQ-034 Macro off, same stimulus as REQ-033 -> grant stays 1000 for 1000 cycles; timeout stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter: per-requester byte streams
// on one side, a single UART transmitter handshake on the other.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic              timeout;

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, grant, tx_start, tx_byte, timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, grant, tx_start, tx_byte, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter feeding one UART transmitter from NREQ byte streams.
// Define UART_ARB_TIMEOUT_EN to add the idle-hold watchdog that revokes a stalled grant.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic             clk,
    input logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, START, WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_rr_ptr, r_owner, w_pick, w_off, w_owner_inc;
    logic [PW:0]     w_sum;
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] r_grant, r_ready;
    logic            r_tx_start, r_last;
    logic [7:0]      r_tx_byte;
    logic            w_any_valid, w_own_valid, w_timeout_hit;
    logic            w_load, w_accept, w_start, w_release;

    assign w_any_valid = |bus.req_valid;
    assign w_own_valid = bus.req_valid[r_owner];
    assign w_owner_inc = (r_owner == PW'(NREQ-1)) ? '0 : r_owner + 1'b1;

    // Rotate so bit 0 is rr_ptr; the lowest set bit is the next owner.
    always_comb begin
        w_rot = NREQ'({bus.req_valid, bus.req_valid} >> r_rr_ptr);
        w_off = '0;
        for (int i = NREQ-1; i >= 0; i--)
            if (w_rot[i]) w_off = PW'(i);
        w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_pick = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] r_wd_cnt;
    logic          r_timeout;

    assign w_timeout_hit = (r_state == HOLD) && !w_own_valid &&
                           (r_wd_cnt == CW'(TIMEOUT_CYC-1));

    // Held at zero outside HOLD, so every HOLD entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if (r_state != HOLD || w_own_valid || w_timeout_hit) r_wd_cnt <= '0;
            else                                                 r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign bus.timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (w_any_valid) w_state_nxt = HOLD;
            HOLD:  if (w_timeout_hit)    w_state_nxt = IDLE;
                   else if (w_own_valid) w_state_nxt = START;
            START: w_state_nxt = WAIT;
            WAIT:  if (bus.tx_done) w_state_nxt = r_last ? IDLE : HOLD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load    = 1'b0;
        w_accept  = 1'b0;
        w_start   = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            IDLE:  w_load = w_any_valid;
            HOLD:  begin
                w_accept  = w_own_valid;
                w_release = w_timeout_hit;
            end
            START: w_start = 1'b1;
            WAIT:  w_release = bus.tx_done & r_last;
            default: ;
        endcase
    end

    // Outputs are registered off the decoded actions, one cycle behind the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant    <= '0;
            r_ready    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_last     <= 1'b0;
        end else begin
            r_ready    <= '0;
            r_tx_start <= w_start;
            if (w_load) begin
                r_owner <= w_pick;
                r_grant <= NREQ'(1) << w_pick;
            end
            if (w_accept) begin
                r_ready   <= NREQ'(1) << r_owner;
                r_tx_byte <= bus.req_data[8*r_owner +: 8];
                r_last    <= bus.req_last[r_owner];
            end
            if (w_release) begin
                r_grant  <= '0;
                r_rr_ptr <= w_owner_inc;
            end
        end
    end

    assign bus.grant     = r_grant;
    assign bus.req_ready = r_ready;
    assign bus.tx_start  = r_tx_start;
    assign bus.tx_byte   = r_tx_byte;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized + directed bench for uart_tx_arbiter against a transaction-level
// model of the arbitration rules (round-robin pick, message lock, latency, watchdog).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int M_IDLE = 0, M_HOLD = 1, M_XFER = 2, M_TX = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_arbiter_if #(.NREQ(N)) bus ();

    uart_tx_arbiter #(.NREQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Stimulus state: per-lane byte queues {last, data}, one copy for the driver, one for the model.
    logic [8:0] drv_q [N][$];
    logic [8:0] mdl_q [N][$];
    int         gap [N];
    logic [N-1:0] xfer = '0;
    int  tx_pend  = 0;
    int  tx_dly   = 10;
    bit  rnd_mode = 0;
    bit  man_done = 0;
    int  n_gen    = 0;

    // Reference model state
    int          ph = M_IDLE, own = -1, rr = 0, idle_n = 0;
    logic [7:0]  exp_byte = 8'h00;
    logic        cur_last = 1'b0;
    logic [N-1:0] p_valid = '0, prev_g = '0;
    logic        p_done = 1'b0, p_rst = 1'b1;
    int          n_to = 0;
    int          glog[$];
    logic [7:0]  txlog[$];

    function automatic int pick(input logic [N-1:0] v, input int r);
        for (int k = 0; k < N; k++)
            if (v[(r+k)%N]) return (r+k)%N;
        return -1;
    endfunction

    function automatic logic [31:0] pk_tx(input logic [7:0] q[$]);
        logic [31:0] acc = '0;
        for (int k = 0; k < q.size(); k++) acc = (acc << 8) | 32'(q[k]);
        return acc;
    endfunction

    function automatic logic [31:0] pk_g(input int q[$]);
        logic [31:0] acc = '0;
        for (int k = 0; k < q.size(); k++) acc = (acc << 4) | 32'(q[k] + 1);
        return acc;
    endfunction

    // Model advances on last cycle's inputs, then checks this cycle's outputs.
    always @(negedge clk) begin : mon
        logic [N-1:0] er;
        logic         es, eto;
        logic [8:0]   ent;
        er = '0; es = 1'b0; eto = 1'b0;
        if (p_rst) begin
            ph = M_IDLE; own = -1; rr = 0; idle_n = 0;
            exp_byte = 8'h00; cur_last = 1'b0;
        end else begin
            case (ph)
                M_IDLE: if (p_valid != '0) begin
                    own = pick(p_valid, rr); ph = M_HOLD; idle_n = 0;
                end
                M_HOLD: if (p_valid[own]) begin
                    er[own] = 1'b1; ph = M_XFER;
                    if (mdl_q[own].size() > 0) begin
                        ent = mdl_q[own].pop_front();
                        exp_byte = ent[7:0]; cur_last = ent[8];
                    end
                end else begin
`ifdef UART_ARB_TIMEOUT_EN
                    idle_n++;
                    if (idle_n == TO) begin
                        eto = 1'b1; rr = (own+1)%N; own = -1; ph = M_IDLE;
                    end
`endif
                end
                M_XFER: begin es = 1'b1; ph = M_TX; end
                M_TX: if (p_done) begin
                    if (cur_last) begin rr = (own+1)%N; own = -1; ph = M_IDLE; end
                    else begin ph = M_HOLD; idle_n = 0; end
                end
                default: ph = M_IDLE;
            endcase
        end
        chk("grant",    32'(bus.grant),     (own < 0) ? 32'd0 : (32'd1 << own));
        chk("ready",    32'(bus.req_ready), 32'(er));
        chk("tx_start", 32'(bus.tx_start),  32'(es));
        chk("tx_byte",  32'(bus.tx_byte),   32'(exp_byte));
        chk("timeout",  32'(bus.timeout),   32'(eto));
        if (bus.grant != '0 && prev_g == '0)
            for (int k = 0; k < N; k++) if (bus.grant[k]) glog.push_back(k);
        if (bus.tx_start) txlog.push_back(bus.tx_byte);
        if (bus.timeout)  n_to++;
        xfer    = bus.req_valid & bus.req_ready;
        prev_g  = bus.grant;
        p_valid = bus.req_valid;
        p_done  = bus.tx_done;
        p_rst   = reset;
    end

    task automatic put(input int i, input logic [7:0] b, input logic last);
        drv_q[i].push_back({last, b});
        mdl_q[i].push_back({last, b});
        n_gen++;
    endtask

    // One clock: transmitter model, then requester drivers (valid held until accepted).
    task automatic step();
        @(posedge clk); #1;
        bus.tx_done = 1'b0;
        if (man_done) begin
            bus.tx_done = 1'b1; man_done = 0;
        end else if (tx_pend > 0) begin
            tx_pend--;
            if (tx_pend == 0) bus.tx_done = 1'b1;
        end else if (rnd_mode && !bus.tx_start && $urandom_range(0, 15) == 0) begin
            bus.tx_done = 1'b1;
        end
        if (bus.tx_start && !reset) tx_pend = rnd_mode ? int'($urandom_range(1, 8)) : tx_dly;
        for (int i = 0; i < N; i++) begin
            if (xfer[i] && drv_q[i].size() > 0) begin
                void'(drv_q[i].pop_front());
                gap[i] = rnd_mode ? int'($urandom_range(0, 3)) : 0;
            end
            if (rnd_mode && drv_q[i].size() == 0 && $urandom_range(0, 5) == 0) begin
                int len = int'($urandom_range(1, 3));
                for (int k = 0; k < len; k++) put(i, 8'($urandom_range(0, 255)), k == len-1);
            end
            if (gap[i] > 0) begin
                gap[i]--;
                bus.req_valid[i] = 1'b0;
            end else begin
                bus.req_valid[i] = drv_q[i].size() > 0;
            end
            bus.req_data[8*i +: 8] = (drv_q[i].size() > 0) ? drv_q[i][0][7:0] : 8'h00;
            bus.req_last[i]        = (drv_q[i].size() > 0) ? drv_q[i][0][8]   : 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete(); mdl_q[i].delete(); gap[i] = 0;
        end
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_done = 1'b0;
        tx_pend = 0; man_done = 0;
        repeat (n) step();
        reset = 1'b0;
        glog.delete(); txlog.delete();
    endtask

    task automatic drain(input int budget, input string tag);
        int  c = 0;
        bit  busy = 1;
        while (busy && c < budget) begin
            step(); c++;
            busy = (tx_pend != 0) || (bus.grant != '0) || (bus.req_valid != '0);
            for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) busy = 1;
        end
        chk(tag, 32'(c < budget), 32'd1);
        repeat (3) step();
    endtask

    initial begin : main
        int c, to0;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_done = 1'b0;
        for (int i = 0; i < N; i++) gap[i] = 0;

        // Single two-byte message from req0, then a tie between req0/req1 exposes rr_ptr=1.
        do_reset(3);
        tx_dly = 10;
        put(0, 8'h41, 1'b0); put(0, 8'h42, 1'b1);
        drain(300, "single_drain");
        chk("single_bytes",  pk_tx(txlog), 32'h4142);
        chk("single_grants", pk_g(glog),   32'h1);
        glog.delete(); txlog.delete();
        put(0, 8'h10, 1'b1); put(1, 8'h11, 1'b1);
        drain(300, "rr_drain");
        chk("rr_grants", pk_g(glog),   32'h21);
        chk("rr_bytes",  pk_tx(txlog), 32'h1110);

        // All four contend from reset.
        do_reset(2);
        tx_dly = 3;
        for (int i = 0; i < N; i++) put(i, 8'hA0 + 8'(i), 1'b1);
        drain(300, "cont_drain");
        chk("cont_grants", pk_g(glog),   32'h1234);
        chk("cont_bytes",  pk_tx(txlog), 32'hA0A1A2A3);

        // Three-byte message from req1 locks out req2.
        do_reset(2);
        put(1, 8'hB1, 1'b0); put(1, 8'hB2, 1'b0); put(1, 8'hB3, 1'b1); put(2, 8'hC1, 1'b1);
        drain(300, "lock_drain");
        chk("lock_grants", pk_g(glog),   32'h23);
        chk("lock_bytes",  pk_tx(txlog), 32'hB1B2B3C1);

        // Reset while a byte is in flight; the late tx_done must be ignored.
        do_reset(2);
        tx_dly = 10;
        put(0, 8'h51, 1'b0); put(0, 8'h52, 1'b1);
        c = 0;
        while (!bus.tx_start && c < 20) begin step(); c++; end
        chk("rstw_start_seen", 32'(c < 20), 32'd1);
        step(); step();
        do_reset(1);
        man_done = 1;
        repeat (20) step();
        chk("rstw_tx_cnt", 32'(txlog.size()), 32'd0);
        chk("rstw_gnt_cnt", 32'(glog.size()), 32'd0);
        chk("rstw_grant",   32'(bus.grant),   32'd0);
        chk("rstw_byte",    32'(bus.tx_byte), 32'd0);

        // Randomized traffic, spurious tx_done pulses, random gaps between bytes.
        do_reset(2);
        n_gen = 0;
        rnd_mode = 1;
        repeat (3000) step();
        rnd_mode = 0;
        drain(2000, "rnd_drain");
        chk("rnd_bytes", 32'(txlog.size()), 32'(n_gen));

        // req3 stalls mid-message while req0 waits.
        do_reset(2);
        tx_dly = 4;
        to0 = n_to;
        put(3, 8'h33, 1'b0);
        c = 0;
        while (bus.grant == '0 && c < 10) begin step(); c++; end
        chk("stall_granted", 32'(bus.grant), 32'h8);
        put(0, 8'h30, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        c = 0;
        while (!bus.timeout && c < 200) begin step(); c++; end
        chk("to_seen",  32'(bus.timeout), 32'd1);
        chk("to_grant", 32'(bus.grant),   32'd0);
        drain(300, "to_drain");
        chk("to_grants", pk_g(glog),   32'h41);
        chk("to_bytes",  pk_tx(txlog), 32'h3330);
        chk("to_count",  32'(n_to - to0), 32'd1);
`else
        repeat (1000) step();
        chk("hold_grant", 32'(bus.grant),   32'h8);
        chk("hold_grants", pk_g(glog),      32'h4);
        chk("hold_bytes", pk_tx(txlog),     32'h33);
        chk("hold_to_cnt", 32'(n_to - to0), 32'd0);
`endif
        do_reset(2);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin : wdog
        #2000000;
        $display("FAIL sim_watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
